// File: rtl/note_tone_gen.sv
// note_tone_gen: one-hot note + octave + volume -> square tone and PCM stream.
// Ports: clk, rst (async, active-high); i_note one-hot (bit11=C .. bit0=B),
//   i_octave (freq x 2^oct), i_volume (0..15); o_square buzzer tone;
//   o_sample/o_valid/i_ready PCM handshake; o_overrun drop pulse; o_busy.
// Build option: NOTE_TONE_GEN_ENVELOPE_EN adds an attack/sustain/release
//   level envelope stepped every env_step sample ticks.
module note_tone_gen #(
   parameter int clk_mhz    = 50,
   parameter int w_note     = 12,
   parameter int w_sample   = 24,
   parameter int sample_div = 1042,
   parameter int env_step   = 48
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [w_note-1:0]   i_note,
   input  logic [1:0]          i_octave,
   input  logic [3:0]          i_volume,
   output logic                o_square,
   output logic [w_sample-1:0] o_sample,
   output logic                o_valid,
   input  logic                i_ready,
   output logic                o_overrun,
   output logic                o_busy
);

   localparam int SDW = $clog2(sample_div + 1);
   localparam longint unsigned CLK_X100 = 64'(clk_mhz) * 64'd100_000_000;

   // Half period in clocks for octave 4, from frequency in Hz*100.
   function automatic logic [19:0] half_of(input longint unsigned f100);
      longint unsigned q;
      q = CLK_X100 / (64'd2 * f100);
      return q[19:0];
   endfunction

   // Index 0 = C ... 11 = B.
   localparam logic [19:0] HALF [12] = '{
      half_of(64'd26163), half_of(64'd27718), half_of(64'd29366),
      half_of(64'd31113), half_of(64'd32963), half_of(64'd34923),
      half_of(64'd36999), half_of(64'd39200), half_of(64'd41530),
      half_of(64'd44000), half_of(64'd46616), half_of(64'd49388)
   };

`ifdef NOTE_TONE_GEN_ENVELOPE_EN
   localparam int EW = $clog2(env_step + 1);
   typedef enum logic [1:0] {
      S_IDLE, S_ATTACK, S_SUSTAIN, S_RELEASE
   } state_e;
   localparam state_e S_ENTRY = S_ATTACK;
`else
   typedef enum logic {S_IDLE, S_PLAY} state_e;
   localparam state_e S_ENTRY = S_PLAY;
`endif

   state_e              state_q, state_d;
   logic [19:0]         cnt_q, cnt_d;
   logic [19:0]         hp_q, hp_d;
   logic                sq_q, sq_d;
   logic [SDW-1:0]      sdiv_q, sdiv_d;
   logic [w_sample-1:0] sample_q, sample_d;
   logic                valid_q, valid_d;
   logic                ovr_q, ovr_d;

   logic [3:0]          note_cnt;
   logic [19:0]         note_hp;
   logic [19:0]         hp_in;
   logic                note_ok;
   logic                tick;
   logic                wrap;
   logic [3:0]          level;
   logic [w_sample-1:0] amp;

`ifdef NOTE_TONE_GEN_ENVELOPE_EN
   logic [3:0]    level_q, level_d;
   logic [EW-1:0] env_q, env_d;
   logic          step;
`endif

   // Multi-hot vectors are counted so they decode as silence.
   always_comb begin
      note_cnt = '0;
      note_hp  = '0;
      for (int i = 0; i < w_note; i++) begin
         if (i_note[i]) begin
            note_cnt = note_cnt + 4'd1;
            note_hp  = HALF[w_note-1-i];
         end
      end
   end

   assign note_ok = (note_cnt == 4'd1);
   assign hp_in   = note_hp >> i_octave;
   assign tick    = (sdiv_q == SDW'(sample_div - 1));
   assign wrap    = (state_q != S_IDLE) && (cnt_q == hp_q - 20'd1);

`ifdef NOTE_TONE_GEN_ENVELOPE_EN
   assign step  = tick && (env_q == EW'(env_step - 1));
   assign level = level_q;
`else
   assign level = (state_q == S_PLAY) ? i_volume : 4'd0;
`endif

   // Tone: inputs only take effect at a wrap, so halves never glitch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 20'd1;
      hp_d    = hp_q;
      sq_d    = sq_q;
      if (state_q == S_IDLE) begin
         cnt_d = '0;
         sq_d  = 1'b0;
         if (note_ok) begin
            state_d = S_ENTRY;
            hp_d    = hp_in;
         end
      end else if (wrap) begin
         cnt_d = '0;
         sq_d  = ~sq_q;
`ifdef NOTE_TONE_GEN_ENVELOPE_EN
         if (note_ok) hp_d = hp_in;
`else
         if (note_ok) begin
            hp_d = hp_in;
         end else begin
            state_d = S_IDLE;
            sq_d    = 1'b0;
         end
`endif
      end
`ifdef NOTE_TONE_GEN_ENVELOPE_EN
      level_d = level_q;
      env_d   = env_q;
      if (tick) env_d = step ? '0 : env_q + EW'(1);
      unique case (state_q)
         S_IDLE: begin
            level_d = '0;
            env_d   = '0;
         end
         S_ATTACK: begin
            if (wrap && !note_ok) state_d = S_RELEASE;
            else if (level_q >= i_volume) state_d = S_SUSTAIN;
            else if (step) level_d = level_q + 4'd1;
         end
         S_SUSTAIN: begin
            level_d = i_volume;
            if (wrap && !note_ok) state_d = S_RELEASE;
         end
         S_RELEASE: begin
            if (level_q == 4'd0) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               sq_d    = 1'b0;
            end else begin
               if (wrap && note_ok) state_d = S_ATTACK;
               if (step) level_d = level_q - 4'd1;
            end
         end
         default: ;
      endcase
`endif
   end

   // Sample stream: amp = level << (w_sample-5), level 1 -> 0x080000.
   always_comb begin
      sdiv_d   = tick ? '0 : sdiv_q + SDW'(1);
      amp      = {{(w_sample-4){1'b0}}, level} << (w_sample - 5);
      sample_d = sample_q;
      valid_d  = valid_q;
      ovr_d    = 1'b0;
      if (tick) begin
         sample_d = sq_q ? amp : -amp;
         valid_d  = 1'b1;
         ovr_d    = valid_q & ~i_ready;
      end else if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         hp_q     <= '0;
         sq_q     <= 1'b0;
         sdiv_q   <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hp_q     <= hp_d;
         sq_q     <= sq_d;
         sdiv_q   <= sdiv_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
      end
   end

`ifdef NOTE_TONE_GEN_ENVELOPE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q <= '0;
         env_q   <= '0;
      end else begin
         level_q <= level_d;
         env_q   <= env_d;
      end
   end
`endif

   assign o_square  = sq_q;
   assign o_sample  = sample_q;
   assign o_valid   = valid_q;
   assign o_overrun = ovr_q;
   assign o_busy    = (state_q != S_IDLE);

endmodule
